// File: rtl/masked_mult_gf2n_pipe.sv
// masked_mult_gf2n_pipe: second-order (3-share) masked GF(2^N) multiplier.
// Ring-refreshed cross products are registered, then compressed to 3 output shares.
// Ports: clk; rst_n (synchronous, active-low);
//        in_valid/in_ready, a1..a3, b1..b3, r (9 words of N bits);
//        out_valid/out_ready, y1..y3 (output shares of a*b).
module masked_mult_gf2n_pipe #(
    parameter int           N       = 4,
    parameter logic [N-1:0] POLY    = 4'h3,
    parameter bit           OUT_REG = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   a2,
    input  logic [N-1:0]   a3,
    input  logic [N-1:0]   b1,
    input  logic [N-1:0]   b2,
    input  logic [N-1:0]   b3,
    input  logic [9*N-1:0] r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   y1,
    output logic [N-1:0]   y2,
    output logic [N-1:0]   y3
);

    // Shift-and-add multiply with reduction folded into each doubling.
    function automatic logic [N-1:0] gf_mul(
        input logic [N-1:0] x,
        input logic [N-1:0] y
    );
        logic [N-1:0] acc;
        logic [N-1:0] sh;
        acc = '0;
        sh  = x;
        for (int i = 0; i < N; i++) begin
            if (y[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[N-1] ? ((sh << 1) ^ POLY) : (sh << 1);
        end
        return acc;
    endfunction

    logic [N-1:0] w_a [3];
    logic [N-1:0] w_b [3];
    logic [N-1:0] w_r [9];
    logic [N-1:0] w_p [9];
    logic [N-1:0] w_c [3];
    logic         w_acc;
    logic         w_adv1;

    logic         r_v1;
    logic [N-1:0] r_p [9];

    assign w_a[0] = a1;
    assign w_a[1] = a2;
    assign w_a[2] = a3;
    assign w_b[0] = b1;
    assign w_b[1] = b2;
    assign w_b[2] = b3;

    for (genvar k = 0; k < 9; k++) begin : g_rword
        assign w_r[k] = r[k*N +: N];
    end

    // Each product touches one share of a and one of b only; the
    // ring refresh keeps every registered term uniformly masked.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_p[k] = gf_mul(w_a[k % 3], w_b[k / 3])
                   ^ w_r[k] ^ w_r[(k + 1) % 9];
        end
    end

    assign w_acc = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_p[k] <= '0;
            end
        end else begin
            if (w_acc) begin
                r_v1 <= 1'b1;
            end else if (w_adv1) begin
                r_v1 <= 1'b0;
            end
            // Hold while idle or stalled so no fresh r is mixed in.
            if (w_acc) begin
                for (int k = 0; k < 9; k++) begin
                    r_p[k] <= w_p[k];
                end
            end
        end
    end

    assign w_c[0] = r_p[0] ^ r_p[1] ^ r_p[2];
    assign w_c[1] = r_p[3] ^ r_p[4] ^ r_p[5];
    assign w_c[2] = r_p[6] ^ r_p[7] ^ r_p[8];

    if (OUT_REG) begin : g_oreg
        logic         r_v2;
        logic [N-1:0] r_y [3];

        assign w_adv1   = r_v1 & (~r_v2 | out_ready);
        assign in_ready = ~r_v1 | ~r_v2 | out_ready;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_v2 <= 1'b0;
                for (int m = 0; m < 3; m++) begin
                    r_y[m] <= '0;
                end
            end else begin
                if (w_adv1) begin
                    r_v2 <= 1'b1;
                    for (int m = 0; m < 3; m++) begin
                        r_y[m] <= w_c[m];
                    end
                end else if (out_ready) begin
                    r_v2 <= 1'b0;
                end
            end
        end

        assign out_valid = r_v2;
        assign y1        = r_y[0];
        assign y2        = r_y[1];
        assign y3        = r_y[2];
    end else begin : g_direct
        assign w_adv1    = r_v1 & out_ready;
        assign in_ready  = ~r_v1 | out_ready;
        assign out_valid = r_v1;
        assign y1        = w_c[0];
        assign y2        = w_c[1];
        assign y3        = w_c[2];
    end

endmodule

// File: doc/masked_mult_gf2n_pipe.md
Name: masked_mult_gf2n_pipe

Overview:
- Second-order (3-share, d+1) masked multiplier over GF(2^N), polynomial basis, reduction polynomial set by parameter.
- Successor of the fixed GF(16) masked multiplier. Adds parametrised field width and polynomial, optional output register stage, and valid/ready flow control with stall-safe randomness consumption.
- Sits inside the masked S-box / inversion datapath. Any stage there that needs a shared GF(2^N) product uses it.

Parameters:
N, 4, field width in bits (legal 2..8).
POLY, 4'h3, low N bits of the irreducible polynomial, x^N term implied (N=8 AES: 8'h1B).
OUT_REG, 0, 1 = extra register after compression (latency 2); 0 = compression directly from product registers (latency 1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous reset, active-low.
in_valid  in  1  input shares and r valid this cycle.
in_ready  out  1  block accepts input this cycle.
a1,a2,a3  in  N each  shares of operand a.
b1,b2,b3  in  N each  shares of operand b.
r  in  9*N  fresh randomness, word k = r[k*N +: N], k=0..8.
out_valid  out  1  y shares valid.
out_ready  in  1  consumer accepts y this cycle.
y1,y2,y3  out  N each  shares of a*b.

Behaviour:
- Reset: when rst_n=0 at a clock edge, all valid flags, product registers and output registers clear to 0. y1..y3=0 and out_valid=0 from the next edge. in_ready is combinational and follows the rules below.
- Reset mid-operation discards in-flight data. No partial output appears after reset.
- Cross products are p_k for k=1..9, ordered (a1b1, a2b1, a3b1, a1b2, a2b2, a3b2, a1b3, a2b3, a3b3). Each is a full GF(2^N) multiply reduced by POLY.
- Ring refresh at registration: p_reg_k <= p_k ^ r[(k-1)] ^ r[k mod 9], using word indices.
- Compression, always from registered values:
  - y1 = p_reg1^p_reg2^p_reg3
  - y2 = p_reg4^p_reg5^p_reg6
  - y3 = p_reg7^p_reg8^p_reg9
- No combinational path may mix shares before a register.
- Stage 1 (product registers) loads only on accept (in_valid & in_ready). Otherwise it holds value; it never reloads with new r while stalled.
- OUT_REG=0:
  - out_valid = stage-1 valid flag.
  - in_ready = ~out_valid | out_ready.
  - Latency 1 cycle.
- OUT_REG=1:
  - Stage 2 loads the compression result when stage 1 is valid and stage 2 is empty or being drained.
  - in_ready = ~v1 | ~v2 | out_ready.
  - Latency 2 cycles. Full throughput of 1/cycle with out_ready=1.
- Stage-1 valid flag on accept-without-advance becomes 1. On advance-without-accept (stage 2 or consumer takes it) it becomes 0. When both happen in the same cycle it stays 1 with new data.
- While out_valid=1 and out_ready=0, y1..y3 are stable.
- in_valid=0 cycles leave data registers untouched. Idle gating is intentional, to avoid glitch leakage.
- Correctness: y1^y2^y3 = (a1^a2^a3)*(b1^b2^b3) for all inputs and all r.

Test Plan:
- N=4, POLY=3, OUT_REG=0, a=(2,0,0), b=(8,0,0), r=0, out_ready=1 -> out_valid one cycle after accept, y1^y2^y3=4'h3.
- N=4, a shares (5,7,5) (a=7), b shares (C,3,6) (b=9), random r -> unmasked y=4'hA. Repeat 1000 random vectors against a software GF(16) model.
- N=8, POLY=8'h1B, OUT_REG=1, a=8'h57, b=8'h83 randomly shared -> y XOR = 8'hC1 two cycles after accept. Back-to-back stream of 16 vectors with out_ready=1 -> one result per cycle, in order.
- All shares 0, r words r0..r8 random -> y1=r0^r3, y2=r3^r6, y3=r6^r0, XOR=0.
- Stall: out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops once the pipe is full, y unchanged, no vector lost or duplicated after release.
- Assert rst_n=0 for one cycle while 2 results are in flight -> out_valid=0 and y=0 next cycle, no stale result emerges afterwards.
